// File: rtl/cmd_stream_arbiter.sv
// Packet-atomic round-robin merge of NUM_SRC AXI-Stream command sources; CMD_ARB_WATCHDOG_EN adds stall abort/discard.
// One arbitration bubble, then a zero-cycle data path; downstream tready passes straight through to the granted source.
module cmd_stream_arbiter #(
    parameter int          NUM_SRC     = 2,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [31:0] ABORT_WORD  = 32'hDEAD_0000
) (
    input  logic                    axi_tclk_i,
    input  logic                    axi_tresetn_i,
    input  logic [NUM_SRC*32-1:0]   s_axis_tdata,
    input  logic [NUM_SRC-1:0]      s_axis_tvalid,
    input  logic [NUM_SRC-1:0]      s_axis_tlast,
    output logic [NUM_SRC-1:0]      s_axis_tready,
    output logic [31:0]             m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_tready,
    output logic [1:0]              grant_id,
    output logic                    busy,
    output logic [15:0]             pkt_count,
    output logic                    timeout_err
);

    typedef enum logic [1:0] {ST_IDLE, ST_LOCK, ST_ABORT, ST_DISCARD} state_t;

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  last_grant_q, last_grant_d;
    logic [15:0] pkt_cnt_q, pkt_cnt_d;

    // Sources padded to four lanes so the grant index never selects out of range.
    logic [127:0] dat_pad;
    logic [3:0]   vld_pad, last_pad, rdy_pad;
    logic [31:0]  g_dat;
    logic         g_vld, g_last;
    logic [2:0]   cand;
    logic [1:0]   pick;
    logic         found;

`ifdef CMD_ARB_WATCHDOG_EN
    localparam logic [15:0] STALL_LAST = 16'(TIMEOUT_CYC - 1);
    logic [15:0] stall_q, stall_d;
    logic        tout_q, tout_d;
`else
    logic unused_cfg;
    assign unused_cfg = ^{ABORT_WORD, 16'(TIMEOUT_CYC)};
`endif

    always_comb begin
        dat_pad  = '0;
        vld_pad  = '0;
        last_pad = '0;
        dat_pad[NUM_SRC*32-1:0] = s_axis_tdata;
        vld_pad[NUM_SRC-1:0]    = s_axis_tvalid;
        last_pad[NUM_SRC-1:0]   = s_axis_tlast;
        g_dat  = dat_pad[{grant_q, 5'd0} +: 32];
        g_vld  = vld_pad[grant_q];
        g_last = last_pad[grant_q];
    end

    // Round-robin search starting one past the previous winner.
    always_comb begin
        pick  = last_grant_q;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = {1'b0, last_grant_q} + 3'(k);
            if (cand >= 3'(NUM_SRC)) cand = cand - 3'(NUM_SRC);
            if (!found && vld_pad[cand[1:0]]) begin
                pick  = cand[1:0];
                found = 1'b1;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_grant_d  = last_grant_q;
        pkt_cnt_d     = pkt_cnt_q;
        rdy_pad       = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tdata  = g_dat;
        m_axis_tlast  = g_last;
`ifdef CMD_ARB_WATCHDOG_EN
        stall_d = '0;
        tout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
                m_axis_tvalid    = g_vld;
                rdy_pad[grant_q] = m_axis_tready;
                if (g_vld && m_axis_tready && g_last) begin
                    last_grant_d = grant_q;
                    pkt_cnt_d    = pkt_cnt_q + 16'd1;
                    state_d      = ST_IDLE;
                end
`ifdef CMD_ARB_WATCHDOG_EN
                // Only a missing source valid counts; downstream backpressure never does.
                else if (!g_vld) begin
                    if (stall_q == STALL_LAST) begin
                        state_d = ST_ABORT;
                        tout_d  = 1'b1;
                    end else begin
                        stall_d = stall_q + 16'd1;
                    end
                end
`endif
            end
`ifdef CMD_ARB_WATCHDOG_EN
            ST_ABORT: begin
                m_axis_tvalid = 1'b1;
                m_axis_tdata  = ABORT_WORD | {30'd0, grant_q};
                m_axis_tlast  = 1'b1;
                if (m_axis_tready) state_d = ST_DISCARD;
            end
            ST_DISCARD: begin
                rdy_pad[grant_q] = 1'b1;
                if (g_vld && g_last) begin
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge axi_tclk_i or posedge axi_tresetn_i) begin
        if (axi_tresetn_i) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= 2'(NUM_SRC - 1);
            pkt_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            pkt_cnt_q    <= pkt_cnt_d;
        end
    end

`ifdef CMD_ARB_WATCHDOG_EN
    always_ff @(posedge axi_tclk_i or posedge axi_tresetn_i) begin
        if (axi_tresetn_i) begin
            stall_q <= '0;
            tout_q  <= 1'b0;
        end else begin
            stall_q <= stall_d;
            tout_q  <= tout_d;
        end
    end
    assign timeout_err = tout_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign s_axis_tready = rdy_pad[NUM_SRC-1:0];
    assign grant_id      = grant_q;
    assign busy          = (state_q != ST_IDLE);
    assign pkt_count     = pkt_cnt_q;

endmodule

// File: tb/tb_cmd_stream_arbiter.sv
// Bench for cmd_stream_arbiter: directed scenarios, per-cycle model comparison and literal beat-log checks.
module tb_cmd_stream_arbiter;
    localparam int N   = 2;
    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    always #4 clk = ~clk;

    logic [31:0] td [2];
    logic        tv [2];
    logic        tl [2];
    logic [63:0] s_dat;
    logic [1:0]  s_vld, s_last, s_rdy;
    logic [31:0] m_dat;
    logic        m_vld, m_last, m_rdy;
    logic [1:0]  gid;
    logic        busy;
    logic [15:0] pcnt;
    logic        tout;

    assign s_dat  = {td[1], td[0]};
    assign s_vld  = {tv[1], tv[0]};
    assign s_last = {tl[1], tl[0]};

    cmd_stream_arbiter #(.NUM_SRC(N), .TIMEOUT_CYC(TMO), .ABORT_WORD(32'hDEAD_0000)) dut (
        .axi_tclk_i(clk), .axi_tresetn_i(rst),
        .s_axis_tdata(s_dat), .s_axis_tvalid(s_vld), .s_axis_tlast(s_last), .s_axis_tready(s_rdy),
        .m_axis_tdata(m_dat), .m_axis_tvalid(m_vld), .m_axis_tlast(m_last), .m_axis_tready(m_rdy),
        .grant_id(gid), .busy(busy), .pkt_count(pcnt), .timeout_err(tout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic flag_fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait budget expired (t=%0t)", nm, $time);
    endtask

    typedef struct {logic [31:0] d; logic l; logic [1:0] g; int c;} beat_t;
    beat_t log_q[$];
    int    cyc = 0;
    int    tout_cyc = -1;
    int    stall_start = 0;
    bit    tout_seen = 0;
    bit    kill = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural model: owner of the bus and what it is doing with it.
    int mo_own = -1, mo_phase = 0, mo_last = N - 1, mo_pc = 0, mo_stall = 0;
    bit mo_pulse = 0;

    always @(negedge clk) begin
        logic [31:0] e_dat;
        logic        e_vld, e_last, got;
        logic [1:0]  e_rdy;
        int          idx;
        if (rst) begin
            mo_own = -1; mo_phase = 0; mo_last = N - 1; mo_pc = 0; mo_stall = 0; mo_pulse = 0;
        end
        e_vld = 1'b0; e_dat = '0; e_last = 1'b0; e_rdy = '0;
        if (mo_phase == 1) begin
            e_vld = tv[mo_own]; e_dat = td[mo_own]; e_last = tl[mo_own];
            e_rdy = m_rdy ? 2'(1 << mo_own) : 2'b00;
        end else if (mo_phase == 2) begin
            e_vld = 1'b1; e_dat = 32'hDEAD_0000 | 32'(mo_own); e_last = 1'b1;
        end else if (mo_phase == 3) begin
            e_rdy = 2'(1 << mo_own);
        end
        chk("busy", busy, mo_phase != 0);
        if (mo_phase != 0) chk("grant_id", gid, mo_own);
        chk("m_tvalid", m_vld, e_vld);
        if (e_vld) begin
            chk("m_tdata", m_dat, e_dat);
            chk("m_tlast", m_last, e_last);
        end
        chk("s_tready", s_rdy, e_rdy);
        chk("pkt_count", pcnt, mo_pc);
        chk("timeout_err", tout, mo_pulse);
        if (m_vld && m_rdy) log_q.push_back('{m_dat, m_last, gid, cyc});
        if (tout) begin tout_seen = 1; tout_cyc = cyc; end
        if (!rst) begin
            mo_pulse = 0;
            case (mo_phase)
                0: begin
                    got = 0;
                    for (int k = 1; k <= N; k++) begin
                        idx = (mo_last + k) % N;
                        if (!got && tv[idx]) begin got = 1; mo_own = idx; end
                    end
                    if (got) begin mo_phase = 1; mo_stall = 0; end
                end
                1: begin
                    if (tv[mo_own] && m_rdy && tl[mo_own]) begin
                        mo_last = mo_own; mo_pc = (mo_pc + 1) % 65536; mo_phase = 0; mo_own = -1;
                    end
`ifdef CMD_ARB_WATCHDOG_EN
                    else if (!tv[mo_own]) begin
                        mo_stall++;
                        if (mo_stall == TMO) begin mo_phase = 2; mo_pulse = 1; end
                    end else mo_stall = 0;
`endif
                end
                2: if (m_rdy) mo_phase = 3;
                3: if (tv[mo_own] && tl[mo_own]) begin mo_last = mo_own; mo_phase = 0; mo_own = -1; end
                default: mo_phase = 0;
            endcase
        end
    end

    task automatic send(input int src, input int nb, input logic [31:0] base,
                        input int stall_after, input int stall_len);
        int budget;
        for (int b = 0; b < nb; b++) begin
            if (kill) break;
            if (b == stall_after && stall_len > 0) begin
                tv[src] = 1'b0;
                stall_start = cyc;
                repeat (stall_len) @(posedge clk);
                #1;
            end
            tv[src] = 1'b1; td[src] = base + 32'(b + 1); tl[src] = (b == nb - 1);
            budget = 0;
            do begin @(negedge clk); budget++; end while (!s_rdy[src] && !kill && budget < 200);
            if (!s_rdy[src] && !kill) flag_fail("send_wait");
            @(posedge clk); #1;
        end
        tv[src] = 1'b0; tl[src] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    logic [31:0] cont_base [4] = '{32'hA000_0100, 32'hB000_0100, 32'hA000_0200, 32'hB000_0200};
    int t0, pc0, b;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 2; i++) begin tv[i] = 0; tl[i] = 0; td[i] = '0; end
        m_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0); chk("rst_mvld", m_vld, 0); chk("rst_srdy", s_rdy, 0);
        chk("rst_pcnt", pcnt, 0); chk("rst_gid", gid, 0); chk("rst_tout", tout, 0);
        rst = 1'b0;

        // Single source, 4 beats.
        @(posedge clk); #1;
        log_q.delete(); t0 = cyc;
        send(0, 4, 32'h5757_0000, -1, 0);
        repeat (3) @(posedge clk); #1;
        chk("single_n", log_q.size(), 4);
        for (int i = 0; i < log_q.size() && i < 4; i++) begin
            chk("single_dat", log_q[i].d, 32'h5757_0001 + 32'(i));
            chk("single_last", log_q[i].l, i == 3);
        end
        if (log_q.size() > 0) chk("single_lat", log_q[0].c - t0, 1);
        chk("single_pcnt", pcnt, 1);
        chk("single_gid", gid, 0);

        // Contention: both sources, two 3-beat packets each.
        do_reset();
        log_q.delete();
        fork
            begin send(0, 3, cont_base[0], -1, 0); send(0, 3, cont_base[2], -1, 0); end
            begin send(1, 3, cont_base[1], -1, 0); send(1, 3, cont_base[3], -1, 0); end
        join
        repeat (3) @(posedge clk); #1;
        chk("cont_n", log_q.size(), 12);
        for (int i = 0; i < log_q.size() && i < 12; i++) begin
            chk("cont_gid", log_q[i].g, (i / 3) % 2);
            chk("cont_dat", log_q[i].d, cont_base[i / 3] + 32'(i % 3 + 1));
        end
        chk("cont_pcnt", pcnt, 4);

        // Backpressure: tready toggles every cycle during a 6-beat packet.
        tout_seen = 0; log_q.delete();
        fork
            send(0, 6, 32'hC0C0_0000, -1, 0);
            begin repeat (20) begin @(posedge clk); #1; m_rdy = ~m_rdy; end end
        join
        m_rdy = 1'b1;
        repeat (3) @(posedge clk); #1;
        chk("bp_n", log_q.size(), 6);
        for (int i = 0; i < log_q.size() && i < 6; i++)
            chk("bp_dat", log_q[i].d, 32'hC0C0_0001 + 32'(i));
        chk("bp_no_tout", tout_seen, 0);
        chk("bp_pcnt", pcnt, 5);

        // Source 1 stalls mid-packet for 20 cycles.
        tout_seen = 0; tout_cyc = -1; log_q.delete(); pc0 = pcnt;
        send(1, 5, 32'h5A5A_0000, 2, 20);
        repeat (3) @(posedge clk); #1;
`ifdef CMD_ARB_WATCHDOG_EN
        chk("wd_n", log_q.size(), 3);
        if (log_q.size() == 3) begin
            chk("wd_b0", log_q[0].d, 32'h5A5A_0001);
            chk("wd_b1", log_q[1].d, 32'h5A5A_0002);
            chk("wd_abort", log_q[2].d, 32'hDEAD_0001);
            chk("wd_abort_last", log_q[2].l, 1);
        end
        chk("wd_tout_seen", tout_seen, 1);
        chk("wd_tout_delay", tout_cyc - stall_start, 8);
        chk("wd_pcnt", pcnt, pc0);
`else
        chk("nowd_n", log_q.size(), 5);
        for (int i = 0; i < log_q.size() && i < 5; i++) begin
            chk("nowd_dat", log_q[i].d, 32'h5A5A_0001 + 32'(i));
            chk("nowd_last", log_q[i].l, i == 4);
        end
        chk("nowd_tout", tout_seen, 0);
        chk("nowd_pcnt", pcnt, pc0 + 1);
`endif

        // Asynchronous reset in the middle of a packet.
        log_q.delete();
        fork
            send(0, 4, 32'h7E7E_0000, -1, 0);
            begin
                b = 0;
                while (log_q.size() < 2 && b < 100) begin @(posedge clk); b++; end
                if (log_q.size() < 2) flag_fail("rst_wait");
                #3 rst = 1'b1; kill = 1'b1;
                #1;
                chk("arst_mvld", m_vld, 0); chk("arst_srdy", s_rdy, 0); chk("arst_busy", busy, 0);
                chk("arst_pcnt", pcnt, 0); chk("arst_gid", gid, 0); chk("arst_tout", tout, 0);
                repeat (4) @(posedge clk);
            end
        join
        #1 rst = 1'b0; kill = 1'b0;
        @(posedge clk); #1;
        log_q.delete();
        fork
            send(0, 1, 32'h1100_0000, -1, 0);
            send(1, 1, 32'h2200_0000, -1, 0);
        join
        repeat (3) @(posedge clk); #1;
        chk("post_n", log_q.size(), 2);
        if (log_q.size() == 2) begin
            chk("post_g0", log_q[0].g, 0);
            chk("post_d0", log_q[0].d, 32'h1100_0001);
            chk("post_l0", log_q[0].l, 1);
            chk("post_g1", log_q[1].g, 1);
            chk("post_gap", log_q[1].c - log_q[0].c, 2);
        end
        chk("post_pcnt", pcnt, 2);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/cmd_stream_arbiter.md
# cmd_stream_arbiter

Packet-atomic round-robin arbiter that merges up to four 32-bit AXI-Stream command streams onto the single command bus feeding the command executor. The sources are the Ethernet command decoder, the host debug port and internal sequencers. It sits between those sources and the command executor, all in the 125 MHz AXI clock domain. Once a source is granted, it owns the bus until its `tlast` beat. An optional watchdog terminates and discards packets whose source stalls mid-packet.

## Interface
Parameters:
- `NUM_SRC`, default 2: number of sources. Legal range 2..4.
- `TIMEOUT_CYC`, default 1024: number of consecutive stall cycles before an abort. Legal range 2..65535. Used only with the watchdog.
- `ABORT_WORD`, default 32'hDEAD_0000: base value of the abort beat. The source index is ORed into bits [1:0].

Ports:
- `axi_tclk_i` in 1: clock, 125 MHz.
- `axi_tresetn_i` in 1: reset, asynchronous, active-high.
- `s_axis_tdata` in NUM_SRC*32: source data. Source i occupies bits [32i+31:32i].
- `s_axis_tvalid` in NUM_SRC: per-source valid.
- `s_axis_tlast` in NUM_SRC: per-source last.
- `s_axis_tready` out NUM_SRC: per-source ready.
- `m_axis_tdata` out 32: merged command data.
- `m_axis_tvalid` out 1: merged valid.
- `m_axis_tlast` out 1: merged last.
- `m_axis_tready` in 1: downstream ready.
- `grant_id` out 2: index of the currently granted source. Valid when `busy`=1.
- `busy` out 1: high in LOCK, ABORT and DISCARD.
- `pkt_count` out 16: number of packets completed normally. Wraps at 65535→0.
- `timeout_err` out 1: one-cycle pulse on entry to ABORT.

## Operation
States:
- **IDLE**
  - All `s_axis_tready`=0. `m_axis_tvalid`=0.
  - If any `s_axis_tvalid` is high, select the first requesting source searching from `last_grant+1` modulo NUM_SRC. Register it into `grant_id` and go to LOCK.
- **LOCK**
  - `m_axis_tdata`, `m_axis_tvalid` and `m_axis_tlast` mirror the granted source combinationally.
  - `s_axis_tready[grant]` = `m_axis_tready`. All other readies are 0.
  - On a beat (valid & ready) with `tlast`=1: `last_grant` <= `grant_id`, `pkt_count` +1, go to IDLE.
- **ABORT** (watchdog only)
  - Drive `m_axis_tdata` = ABORT_WORD | grant_id, `m_axis_tvalid`=1, `m_axis_tlast`=1. Source readies are 0.
  - Hold until `m_axis_tready`=1, then go to DISCARD.
- **DISCARD**
  - `s_axis_tready[grant]`=1. `m_axis_tvalid`=0.
  - Consume beats. On a beat with `tlast`=1: `last_grant` <= `grant_id`, go to IDLE. `pkt_count` is not incremented.

Rules:
- Requests from non-granted sources never preempt a locked grant.
- A source that raises and drops `tvalid` before it is granted is still granted if it was sampled high in IDLE. LOCK then waits for it.

## Timing
- Reset values: state IDLE, `last_grant`=NUM_SRC-1 (so source 0 wins first), `grant_id`=0, `busy`=0, `pkt_count`=0, `timeout_err`=0, `m_axis_tvalid`=0, all `s_axis_tready`=0.
- Arbitration takes one bubble cycle. The first beat can transfer one cycle after `tvalid` is sampled in IDLE. Back-to-back packets cost one idle cycle between them.
- The data path adds zero cycles: LOCK is combinational from the granted source to the master port.
- Stall counter:
  - Counts LOCK cycles where `s_axis_tvalid[grant]`=0.
  - Clears on any granted-source valid and on leaving LOCK.
  - Downstream backpressure (`m_axis_tready`=0 with source valid) is not a stall.
  - When the counter equals TIMEOUT_CYC-1 and the source is still invalid, the next state is ABORT and `timeout_err` pulses for 1 cycle.
- If the source raises valid in the same cycle the counter reaches its limit, there is no abort.
- Asynchronous reset mid-packet returns immediately to reset values. Partial packets are not completed.
- A single-beat packet (`tlast` on the first beat) is legal: LOCK lasts 1 cycle when ready.

## Configuration
- `CMD_ARB_WATCHDOG_EN`
  - Defined: stall counter, ABORT and DISCARD states, and `timeout_err` are present.
  - Undefined: the counter and both states are not compiled. `timeout_err` is tied to 0. A stalled source holds its grant indefinitely.

## Test plan
- **Single source:** NUM_SRC=2. Source 0 sends 4 beats 0x57570001..0x57570004 with `tlast` on the 4th, `m_axis_tready`=1.
  - Outputs match in order, first beat one cycle after valid.
  - `pkt_count`=1, `grant_id`=0.
- **Contention:** both sources continuously offer 3-beat packets.
  - Grants alternate 0,1,0,1 with no interleaved beats within a packet.
  - `pkt_count`=4 after 4 packets.
- **Backpressure:** toggle `m_axis_tready` 1-0-1-0 during a 6-beat packet.
  - All 6 beats are delivered exactly once.
  - No `timeout_err` even with TIMEOUT_CYC=4.
- **Watchdog:** TIMEOUT_CYC=8. Source 1 sends 2 beats, then stalls 20 cycles, then sends 3 beats with `tlast`.
  - `timeout_err` pulses 8 cycles after the stall begins.
  - The master sees the 2 beats, then 0xDEAD0001 with `tlast`.
  - The remaining 3 source beats are discarded. `pkt_count` is unchanged.
- **Reset:** assert `axi_tresetn_i` mid-packet on beat 2.
  - All outputs return to their reset values asynchronously.
  - After release, source 0 is granted first.
- **Macro off:** with `CMD_ARB_WATCHDOG_EN` undefined, repeat the watchdog scenario.
  - No abort. The packet completes with 5 beats. `timeout_err`=0.
